// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master side presents operands and consumes results; the adder is the slave.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, A, B, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry, overflow
    );

    modport slave (
        input  in_valid, A, B, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry, overflow
    );
endinterface

// File: rtl/pipelined_adder.sv
// Carry-pipelined add/subtract: each stage adds one STAGE_W-bit chunk using the
// carry registered by the previous stage; a single enable stalls the whole pipe.
module pipelined_adder #(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 4
) (
    input logic             clk,
    input logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = WIDTH / STAGE_W;

    if (WIDTH % STAGE_W != 0) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be a multiple of STAGE_W");
    end

    logic en;

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    // Operands shrink by one chunk per stage while the result grows by one chunk.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int RW = WIDTH - i * STAGE_W;
        localparam int SW = (i + 1) * STAGE_W;

        logic [RW-1:0]      a_in;
        logic [RW-1:0]      bx_in;
        logic               c_in;
        logic               v_in;
        logic [STAGE_W:0]   part;
        logic [SW-1:0]      s_next;
        logic [SW-1:0]      s_q;
        logic               c_q;
        logic               v_q;

        if (i == 0) begin : g_first
            assign a_in   = bus.A;
            assign bx_in  = bus.sub ? ~bus.B : bus.B;
            assign c_in   = bus.sub ? ~bus.cin : bus.cin;
            assign v_in   = bus.in_valid;
            assign s_next = part[STAGE_W-1:0];
        end else begin : g_next
            assign a_in   = g_stage[i-1].g_fwd.a_q;
            assign bx_in  = g_stage[i-1].g_fwd.bx_q;
            assign c_in   = g_stage[i-1].c_q;
            assign v_in   = g_stage[i-1].v_q;
            assign s_next = {part[STAGE_W-1:0], g_stage[i-1].s_q};
        end

        assign part = {1'b0, a_in[STAGE_W-1:0]} + {1'b0, bx_in[STAGE_W-1:0]}
                    + {{STAGE_W{1'b0}}, c_in};

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                s_q <= s_next;
                c_q <= part[STAGE_W];
                v_q <= v_in;
            end
        end

        if (i < STAGES - 1) begin : g_fwd
            logic [RW-STAGE_W-1:0] a_q;
            logic [RW-STAGE_W-1:0] bx_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    bx_q <= '0;
                end else if (en) begin
                    a_q  <= a_in[RW-1:STAGE_W];
                    bx_q <= bx_in[RW-1:STAGE_W];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // Signed overflow: operands agree in sign but the result does not.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= (a_in[RW-1] == bx_in[RW-1]) && (part[STAGE_W-1] != a_in[RW-1]);
                end
            end
        end
    end

    assign bus.sum       = g_stage[STAGES-1].s_q;
    assign bus.carry     = g_stage[STAGES-1].c_q;
    assign bus.overflow  = g_stage[STAGES-1].g_last.ovf_q;
    assign bus.out_valid = g_stage[STAGES-1].v_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a 16/4 instance under random traffic and
// backpressure, plus a 4/4 instance matching the old single-cycle ripple adder.
module tb_pipelined_adder;
    typedef struct {
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    int   stall_count = 0;
    exp_t sbq0[$];
    exp_t sbq1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    pipelined_adder_if #(.WIDTH(16)) bus ();
    pipelined_adder_if #(.WIDTH(4))  bus4 ();

    pipelined_adder #(.WIDTH(16), .STAGE_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    pipelined_adder #(.WIDTH(4), .STAGE_W(4)) dut4 (
        .clk(clk),
        .rst(rst),
        .bus(bus4)
    );

    // Reference model: integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input int width, input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sub_op);
        exp_t   e;
        longint modv = longint'(1) << width;
        longint half = modv / 2;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = (ua >= half) ? ua - modv : ua;
        longint sb = (ub >= half) ? ub - modv : ub;
        longint c  = ci ? 1 : 0;
        longint ur;
        longint sr;
        if (!sub_op) begin
            ur      = ua + ub + c;
            sr      = sa + sb + c;
            e.carry = (ur >= modv);
        end else begin
            ur      = ua - ub - c;
            sr      = sa - sb - c;
            e.carry = (ur >= 0);
        end
        e.sum = 16'(ur & (modv - 1));
        e.ovf = (sr < -half) || (sr >= half);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cycle);
        end
    endtask

    task automatic checkOutput(input int id, input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        int   stg;
        stg = (id == 0) ? 4 : 1;
        if (id == 0) begin
            check("dut16_output_expected", 32'(sbq0.size() != 0), 1);
            if (sbq0.size() == 0) return;
            e = sbq0.pop_front();
        end else begin
            check("dut4_output_expected", 32'(sbq1.size() != 0), 1);
            if (sbq1.size() == 0) return;
            e = sbq1.pop_front();
        end
        check("sum", 32'(s), 32'(e.sum));
        check("carry", 32'(c), 32'(e.carry));
        check("overflow", 32'(o), 32'(e.ovf));
        if (e.lat) check("latency", cycle, e.acc + stg - 1);
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                 input logic sub_op, input bit lat);
        exp_t e;
        int   waited = 0;
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.cin      = ci;
        bus.sub      = sub_op;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", 32'(bus.in_ready), 1);
        if (bus.in_ready) begin
            e     = model(16, a, b, ci, sub_op);
            e.acc = cycle + 1;
            e.lat = lat;
            sbq0.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyLegacy(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        bus4.in_valid = 1'b1;
        bus4.A        = a;
        bus4.B        = b;
        bus4.cin      = 1'b0;
        bus4.sub      = 1'b0;
        @(negedge clk);
        check("legacy_in_ready", 32'(bus4.in_ready), 1);
        if (bus4.in_ready) begin
            e     = model(4, 16'(a), 16'(b), 1'b0, 1'b0);
            e.acc = cycle + 1;
            e.lat = 1'b1;
            sbq1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq0.size() != 0 || sbq1.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", sbq0.size() + sbq1.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor for the 16-bit unit: transfers, output hold and in_ready during stalls.
    initial begin
        bit          stalled = 1'b0;
        logic [15:0] hold_sum = '0;
        logic        hold_c = 1'b0;
        logic        hold_o = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(bus.out_valid), 1);
                    check("hold_sum", 32'(bus.sum), 32'(hold_sum));
                    check("hold_carry", 32'(bus.carry), 32'(hold_c));
                    check("hold_overflow", 32'(bus.overflow), 32'(hold_o));
                end
                if (bus.out_valid && !bus.out_ready) begin
                    stall_count++;
                    check("stall_in_ready", 32'(bus.in_ready), 0);
                end
                if (bus.out_valid && bus.out_ready)
                    checkOutput(0, bus.sum, bus.carry, bus.overflow);
                stalled  = bus.out_valid && !bus.out_ready;
                hold_sum = bus.sum;
                hold_c   = bus.carry;
                hold_o   = bus.overflow;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus4.out_valid && bus4.out_ready)
                checkOutput(1, 16'(bus4.sum), bus4.carry, bus4.overflow);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit stim_done;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.cin        = 1'b0;
        bus.sub        = 1'b0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.A         = '0;
        bus4.B         = '0;
        bus4.cin       = 1'b0;
        bus4.sub       = 1'b0;
        bus4.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_sum", 32'(bus.sum), 0);
        check("reset_carry", 32'(bus.carry), 0);
        check("reset_overflow", 32'(bus.overflow), 0);
        check("reset_in_ready", 32'(bus.in_ready), 1);
        check("reset_dut4_out_valid", 32'(bus4.out_valid), 0);
        @(posedge clk);
        #1;

        $display("[TB] directed add/sub with exact latency");
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        drain();
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'h0010, 16'h0001, 1'b1, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        drain();

        $display("[TB] backpressure mid-stream");
        stall_count = 0;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles_seen", 32'(stall_count >= 3), 1);

        $display("[TB] random traffic with random backpressure");
        stim_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                end
                bus.in_valid = 1'b0;
                stim_done    = 1'b1;
            end
            begin
                while (!stim_done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] reset with operations in flight");
        for (int k = 0; k < 3; k++)
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        sbq0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 32'(bus.out_valid), 0);
        check("midreset_sum", 32'(bus.sum), 0);
        check("midreset_carry", 32'(bus.carry), 0);
        check("midreset_in_ready", 32'(bus.in_ready), 1);
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] 4-bit legacy equivalence");
        applyLegacy(4'b1010, 4'b0011);
        applyLegacy(4'b0010, 4'b1111);
        applyLegacy(4'b0110, 4'b1011);
        bus4.in_valid = 1'b0;
        drain();

        check("leftover_expected", sbq0.size() + sbq1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the team's 4-bit ripple adder.
- Splits a WIDTH-bit operation into WIDTH/STAGE_W carry-pipelined chunks, one chunk per stage.
- Valid/ready handshake on input and output; full throughput of one operation per cycle; backpressure stalls the whole pipe.
- Used as the arithmetic datapath element wherever operand width exceeds single-cycle timing.

Parameters:
- WIDTH, 16, operand and result width in bits.
- STAGE_W, 4, bits added per pipeline stage. WIDTH % STAGE_W != 0 is an elaboration error. STAGES = WIDTH/STAGE_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  unit accepts operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- carry  output  1  carry-out of the WIDTH-bit addition.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Arithmetic, all unsigned mod 2^WIDTH:
  - sub=0: A + B + cin.
  - sub=1: A + ~B + !cin, i.e. A - B - cin.
- carry is the raw carry-out of bit WIDTH-1. In subtract, carry=1 means no borrow.
- overflow = (opA[MSB] == opB'[MSB]) && (sum[MSB] != opA[MSB]), where opB' is B after conditional inversion.
- Pipeline:
  - Stage i (0..STAGES-1) adds chunk i using the carry registered by stage i-1.
  - Upper operand chunks, sub-adjusted B and the valid bit travel alongside.
  - The last stage's registers drive sum/carry/overflow/out_valid directly.
- Enable: en = !out_valid || out_ready. in_ready = en, combinational from out_valid and out_ready. All stage registers (data and valid) advance only when en=1.
- Accept on in_valid && in_ready at a rising edge. When not accepted, stage 0 loads a bubble (valid=0).
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles including the accept edge.
  - Example: WIDTH=16, STAGE_W=4 gives latency 4.
  - Example: STAGES=1 gives result registered one edge after accept.
- Transfer out occurs on out_valid && out_ready. Results leave in acceptance order; no drop or duplication.
- Output hold: while out_valid && !out_ready, sum/carry/overflow/out_valid stay stable and in_ready=0.
- Bubbles: internal bubbles are not collapsed during a stall. When out_valid=0, en=1, so bubbles drain freely.
- Reset, including mid-operation:
  - At the first rising edge with rst=1, all stage valids, out_valid, sum, carry and overflow go to 0, and all in-flight operations are discarded.
  - in_ready=1 in the cycle after reset (out_valid=0).
  - Inputs are ignored while rst=1.
- Simultaneous accept and output transfer in one cycle is legal and required for full throughput.
- No state machine beyond the valid pipeline; no combinational path from A/B to outputs.

Test Plan:
- WIDTH=16, STAGE_W=4, out_ready=1: A=0xA5A5, B=0x5A5A, cin=0, sub=0 -> exactly 4 cycles later sum=0xFFFF, carry=0, overflow=0, out_valid high for 1 cycle.
- Carry chain across all stages: 0xFFFF+0x0001 -> sum=0x0000, carry=1, ovf=0. Then 0x7FFF+0x0001 -> sum=0x8000, carry=0, ovf=1. Then 0x0000+0x0000 with cin=1 -> sum=0x0001.
- Subtract: 0x0003-0x0005, cin=0 -> sum=0xFFFE, carry=0, ovf=0. Then 0x8000-0x0001 -> sum=0x7FFF, carry=1, ovf=1. Then 0x0010-0x0001 with cin=1 -> sum=0x000E, carry=1.
- Backpressure: 8 back-to-back random ops, out_ready held low for 3 cycles mid-stream -> in_ready low in the same cycles, outputs stable while stalled, all 8 results correct against a reference model and in order.
- Reset mid-flight: 3 ops accepted, then rst=1 for 1 cycle -> next cycle out_valid=0, sum=0, carry=0, in_ready=1; no stale result ever appears after rst deasserts.
- Legacy equivalence, WIDTH=4, STAGE_W=4, sub=0, cin=0 (latency 1):
  - 1010+0011 -> sum=1101, carry=0.
  - 0010+1111 -> sum=0001, carry=1.
  - 0110+1011 -> sum=0001, carry=1.
